// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multi-cycle Moore control sequencer for a MIPS datapath. Each instruction
// is stepped through fetch, decode, execute, memory and writeback over a
// single shared memory port. The port uses a ready handshake, so memory can
// insert wait states. The block counts retired instructions and halts on an
// unsupported opcode.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   opcode      IR[31:26], valid from DECODE onward
//   funct       IR[5:0], consumed by ALU control elsewhere (unused here)
//   alu_zero    ALU zero flag (branch decision)
//   mem_ready   memory access completes this cycle
//   pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op   datapath controls
//   state       current state encoding (debug)
//   halted      set while parked in HALT after an illegal opcode
//   instr_count retired-instruction counter (wraps)
module mips_multicycle_ctrl #(
  parameter int OPW  = 6,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic [OPW-1:0]  funct,
  input  logic            alu_zero,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic [1:0]      pc_src,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [3:0]      state,
  output logic            halted,
  output logic [CNTW-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);

  state_t          state_reg;
  state_t          state_next;
  logic            retire;
  logic [CNTW-1:0] count_reg;

  // funct only matters to the ALU decoder; fold it so it is visibly consumed.
  logic funct_unused;
  assign funct_unused = ^funct;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_REXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDIEX;
          default:      state_next = S_HALT;
        endcase
      end
      // Only lw and sw reach MEMADR, so one opcode compare suffices.
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  state_next = S_RWB;
      S_RWB:    state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_HALT;
    endcase
  end

  // An instruction retires on the edge that returns the FSM to FETCH from a
  // final step. MEMWR returns only once its write has been accepted.
  always_comb begin
    retire = 1'b0;
    case (state_reg)
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
      S_MEMWR:                                    retire = mem_ready;
      default:                                    retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_FETCH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        count_reg <= count_reg + CNTW'(1);
      end
    end
  end

  // Moore decode of the datapath controls. The *_raw strobes are masked
  // below so that nothing fires while reset is held low.
  logic pc_en_raw, mem_read_raw, mem_write_raw, ir_write_raw, reg_write_raw;

  always_comb begin
    pc_en_raw     = 1'b0;
    pc_src        = 2'b00;
    iord          = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state_reg)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = 2'b01;
        ir_write_raw = mem_ready;
        pc_en_raw    = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        iord         = 1'b1;
        mem_read_raw = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en_raw = alu_zero;
      end
      S_JUMP: begin
        pc_src    = 2'b10;
        pc_en_raw = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      default: ;
    endcase
  end

  assign pc_en       = pc_en_raw & rst;
  assign mem_read    = mem_read_raw & rst;
  assign mem_write   = mem_write_raw & rst;
  assign ir_write    = ir_write_raw & rst;
  assign reg_write   = reg_write_raw & rst;
  assign state       = state_reg;
  assign halted      = (state_reg == S_HALT);
  assign instr_count = count_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl. A table of per-cycle vectors (inputs
// plus expected state, control word and count) drives a legal instruction
// mix. Hand-written sequences cover reset, halting and a mid-store reset.
// A second instance with a 2-bit counter exercises counter wrap.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        alu_zero;
  logic        mem_ready;
  logic        pc_en, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, halted;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  // Wrap-test instance signals
  logic        w_rst;
  logic [5:0]  w_opcode;
  logic        w_pc_en, w_iord, w_mem_read, w_mem_write, w_ir_write;
  logic        w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a, w_halted;
  logic [1:0]  w_pc_src, w_alu_src_b, w_alu_op;
  logic [3:0]  w_state;
  logic [1:0]  w_count;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OPW(6), .CNTW(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
    .halted(halted), .instr_count(instr_count)
  );

  mips_multicycle_ctrl #(.OPW(6), .CNTW(2)) dut_wrap (
    .clk(clk), .rst(w_rst), .opcode(w_opcode), .funct(6'b100000),
    .alu_zero(1'b0), .mem_ready(1'b1),
    .pc_en(w_pc_en), .pc_src(w_pc_src), .iord(w_iord),
    .mem_read(w_mem_read), .mem_write(w_mem_write),
    .ir_write(w_ir_write), .reg_dst(w_reg_dst),
    .mem_to_reg(w_mem_to_reg), .reg_write(w_reg_write),
    .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op),
    .state(w_state), .halted(w_halted), .instr_count(w_count)
  );

  // Control word: {pc_en, pc_src, iord, mem_read, mem_write, ir_write,
  //                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
  //                alu_op, halted}
  logic [15:0] act_ctrl;
  assign act_ctrl = {pc_en, pc_src, iord, mem_read, mem_write, ir_write,
                     reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                     alu_op, halted};

  //                          pe  psrc  io  mr  mw  irw rd  m2r rw  asa asb   aop   h
  localparam logic [15:0] C_FR  = {1'b1,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0};
  localparam logic [15:0] C_FNR = {1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0};
  localparam logic [15:0] C_DEC = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0};
  localparam logic [15:0] C_MA  = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0};
  localparam logic [15:0] C_MRD = {1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0};
  localparam logic [15:0] C_MWB = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,1'b0};
  localparam logic [15:0] C_MWR = {1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0};
  localparam logic [15:0] C_RX  = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,1'b0};
  localparam logic [15:0] C_RWB = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0};
  localparam logic [15:0] C_BRT = {1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0};
  localparam logic [15:0] C_BRN = {1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0};
  localparam logic [15:0] C_JMP = {1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0};
  localparam logic [15:0] C_AWB = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0};
  localparam logic [15:0] C_HLT = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1};
  localparam logic [15:0] C_RST = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0};

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic        z;
    logic [3:0]  exp_state;
    logic [15:0] exp_ctrl;
    logic [31:0] exp_count;
  } vec_t;

  localparam int NVEC = 34;
  vec_t vecs[NVEC];
  int   nfill;
  int   errors;
  int   checks;

  task automatic add(input logic [5:0] op, input logic rdy, input logic z,
                     input logic [3:0] st, input logic [15:0] ctrl,
                     input logic [31:0] cnt);
    vecs[nfill].op        = op;
    vecs[nfill].rdy       = rdy;
    vecs[nfill].z         = z;
    vecs[nfill].exp_state = st;
    vecs[nfill].exp_ctrl  = ctrl;
    vecs[nfill].exp_count = cnt;
    nfill++;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    nfill     = 0;
    rst       = 1'b0;
    opcode    = 6'b001000;
    funct     = 6'b100000;
    alu_zero  = 1'b0;
    mem_ready = 1'b1;
    w_rst     = 1'b0;
    w_opcode  = 6'b000010;

    // addi: FETCH, DECODE, ADDIEX, ADDIWB
    add(6'h08, 1, 0, 4'd0,  C_FR,  0);
    add(6'h08, 1, 0, 4'd1,  C_DEC, 0);
    add(6'h08, 1, 0, 4'd10, C_MA,  0);
    add(6'h08, 1, 0, 4'd11, C_AWB, 0);
    // R-type add; mem_ready low in REXEC must be ignored
    add(6'h00, 1, 0, 4'd0,  C_FR,  1);
    add(6'h00, 1, 0, 4'd1,  C_DEC, 1);
    add(6'h00, 0, 0, 4'd6,  C_RX,  1);
    add(6'h00, 1, 0, 4'd7,  C_RWB, 1);
    // lw with 2 wait cycles in FETCH and in MEMRD: 9 cycles
    add(6'h23, 0, 0, 4'd0,  C_FNR, 2);
    add(6'h23, 0, 0, 4'd0,  C_FNR, 2);
    add(6'h23, 1, 0, 4'd0,  C_FR,  2);
    add(6'h23, 1, 0, 4'd1,  C_DEC, 2);
    add(6'h23, 1, 0, 4'd2,  C_MA,  2);
    add(6'h23, 0, 0, 4'd3,  C_MRD, 2);
    add(6'h23, 0, 0, 4'd3,  C_MRD, 2);
    add(6'h23, 1, 0, 4'd3,  C_MRD, 2);
    add(6'h23, 1, 0, 4'd4,  C_MWB, 2);
    // sw with one write wait
    add(6'h2B, 1, 0, 4'd0,  C_FR,  3);
    add(6'h2B, 1, 0, 4'd1,  C_DEC, 3);
    add(6'h2B, 1, 0, 4'd2,  C_MA,  3);
    add(6'h2B, 0, 0, 4'd5,  C_MWR, 3);
    add(6'h2B, 1, 0, 4'd5,  C_MWR, 3);
    // beq taken, then not taken
    add(6'h04, 1, 1, 4'd0,  C_FR,  4);
    add(6'h04, 1, 1, 4'd1,  C_DEC, 4);
    add(6'h04, 1, 1, 4'd8,  C_BRT, 4);
    add(6'h04, 1, 0, 4'd0,  C_FR,  5);
    add(6'h04, 1, 0, 4'd1,  C_DEC, 5);
    add(6'h04, 1, 0, 4'd8,  C_BRN, 5);
    // j
    add(6'h02, 1, 0, 4'd0,  C_FR,  6);
    add(6'h02, 1, 0, 4'd1,  C_DEC, 6);
    add(6'h02, 1, 0, 4'd9,  C_JMP, 6);
    // illegal opcode
    add(6'h3F, 1, 0, 4'd0,  C_FR,  7);
    add(6'h3F, 1, 0, 4'd1,  C_DEC, 7);
    add(6'h3F, 1, 0, 4'd15, C_HLT, 7);

    // Reset held 3 cycles with mem_ready high: no strobes, state FETCH
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("reset_ctrl", {16'h0, act_ctrl}, {16'h0, C_RST});
      check("reset_state", {28'h0, state}, 32'd0);
      check("reset_count", instr_count, 32'd0);
    end
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      opcode    = vecs[i].op;
      mem_ready = vecs[i].rdy;
      alu_zero  = vecs[i].z;
      #1;
      $display("vec %0d: op=%02h rdy=%0b z=%0b state=%0d ctrl=%04h count=%0d",
               i, vecs[i].op, vecs[i].rdy, vecs[i].z, state, act_ctrl, instr_count);
      check($sformatf("vec%0d_state", i), {28'h0, state}, {28'h0, vecs[i].exp_state});
      check($sformatf("vec%0d_ctrl", i), {16'h0, act_ctrl}, {16'h0, vecs[i].exp_ctrl});
      check($sformatf("vec%0d_count", i), instr_count, vecs[i].exp_count);
      @(negedge clk);
    end

    // HALT is sticky: 20 more cycles, no strobes, count frozen
    opcode = 6'h00;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      alu_zero  = i[1];
      #1;
      check("halt_state", {28'h0, state}, 32'd15);
      check("halt_ctrl", {16'h0, act_ctrl}, {16'h0, C_HLT});
      check("halt_count", instr_count, 32'd7);
      @(negedge clk);
    end
    $display("halt: held 20 cycles, count=%0d", instr_count);

    // Reset pulse clears halt
    rst = 1'b0;
    #1;
    check("halt_clear", {31'h0, halted}, 32'd0);
    check("halt_clear_state", {28'h0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("post_reset_fetch", {16'h0, act_ctrl}, {16'h0, C_FR});

    // sw reaching MEMWR with memory stalled, then reset mid-write
    opcode = 6'h2B;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("sw_memwr_state", {28'h0, state}, 32'd5);
    check("sw_memwr_write", {31'h0, mem_write}, 32'd1);
    @(negedge clk); #1;
    check("sw_wait_held", {30'h0, iord, mem_write}, 32'd3);
    rst = 1'b0;
    #1;
    check("abort_write", {31'h0, mem_write}, 32'd0);
    check("abort_state", {28'h0, state}, 32'd0);
    check("abort_count", instr_count, 32'd0);
    $display("abort: mem_write=%0b state=%0d count=%0d", mem_write, state, instr_count);
    @(negedge clk); #1;
    check("abort_held_strobes", {27'h0, pc_en, ir_write, mem_read, mem_write, reg_write}, 32'd0);
    rst = 1'b1;

    // 2-bit counter wraps 3 -> 0 after the fourth jump
    @(negedge clk); #1;
    w_rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      repeat (3) @(negedge clk);
      #1;
      $display("wrap j%0d: state=%0d count=%0d", k, w_state, w_count);
      check("wrap_state", {28'h0, w_state}, 32'd0);
      check("wrap_count", {30'h0, w_count}, k % 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
